// File: rtl/t07_spitft_rx.sv
// t07_spitft_rx: SPI read master for the RA8875 TFT controller.
// Sends a command byte on MOSI, then clocks NBYTES data bytes in from MISO.
module t07_spitft_rx #(
    parameter int CLK_DIV = 4,
    parameter int NBYTES  = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ri,
    input  logic [31:0] address,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        busy,
    output logic        chipSelect,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);
    localparam int NBITS = 8 + 8 * NBYTES;
    localparam int RW    = 8 * NBYTES;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
    localparam logic [5:0]    BMAX = 6'(NBITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("t07_spitft_rx: CLK_DIV must be 1 or more");
        end
        if (NBYTES < 1 || NBYTES > 4) begin : g_bad_nbytes
            $error("t07_spitft_rx: NBYTES must be 1..4");
        end
    endgenerate

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_bits;
    logic [7:0]    r_cmd;
    logic [RW-1:0] r_rx;
    logic [31:0]   r_dout;
    logic          r_ack;
    logic          r_busy;
    logic          r_cs;
    logic          r_sclk;
    logic          r_mosi;
    logic          w_tc;
    logic          w_unused;

    assign w_tc       = (r_cnt == CMAX);
    assign w_unused   = ^address[31:8];
    assign data_out   = r_dout;
    assign ack        = r_ack;
    assign busy       = r_busy;
    assign chipSelect = r_cs;
    assign sclk       = r_sclk;
    assign mosi       = r_mosi;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_cmd   <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ri) begin
                        r_cmd   <= address[7:0];
                        r_mosi  <= address[7];
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_bits  <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tc) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_tc) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        // low->high samples MISO; high->low advances MOSI
                        if (!r_sclk) begin
                            r_rx   <= {r_rx[RW-2:0], miso};
                            r_bits <= r_bits + 6'd1;
                        end else begin
                            r_cmd  <= {r_cmd[6:0], 1'b0};
                            r_mosi <= r_cmd[6];
                            if (r_bits == BMAX) begin
                                r_state <= S_HOLD;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_tc) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_ack   <= 1'b1;
                        r_dout  <= 32'(r_rx);
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t07_spitft_rx.sv
// tb_t07_spitft_rx: directed bench for the RA8875 SPI read master.
// Three configurations are exercised against simple mode-0 slave models.
module tb_t07_spitft_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic rnd;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [39:0] got,
                         input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // D=4, NBYTES=4
    logic        ri4, ack4, busy4, cs4, sclk4, mosi4, m4;
    logic [31:0] addr4, dout4;
    logic [39:0] tx4, mo4;
    int          idx4, rise4, csr4, na4;

    t07_spitft_rx #(.CLK_DIV(4), .NBYTES(4)) u4 (
        .clk(clk), .nrst(nrst), .ri(ri4), .address(addr4),
        .data_out(dout4), .ack(ack4), .busy(busy4),
        .chipSelect(cs4), .sclk(sclk4), .mosi(mosi4),
        .miso(m4 | (~nrst & rnd))
    );

    always @(negedge cs4) begin
        idx4 = 0; rise4 = 0; csr4 = 0; m4 = tx4[39];
    end
    always @(negedge sclk4) if (cs4 === 1'b0) begin
        idx4++;
        m4 = (idx4 < 40) ? tx4[39-idx4] : 1'b0;
    end
    always @(posedge sclk4) begin
        rise4++; mo4 = {mo4[38:0], mosi4};
    end
    always @(posedge cs4) csr4++;
    always @(negedge clk) if (ack4 === 1'b1) na4++;

    // D=1, NBYTES=1
    logic        ri1, ack1, busy1, cs1, sclk1, mosi1, m1, seen1;
    logic [31:0] addr1, dout1;
    logic [15:0] tx1, mo1;
    int          idx1, rise1, per1;
    longint      lt1;

    t07_spitft_rx #(.CLK_DIV(1), .NBYTES(1)) u1 (
        .clk(clk), .nrst(nrst), .ri(ri1), .address(addr1),
        .data_out(dout1), .ack(ack1), .busy(busy1),
        .chipSelect(cs1), .sclk(sclk1), .mosi(mosi1),
        .miso(m1 | (~nrst & rnd))
    );

    always @(negedge cs1) begin
        idx1 = 0; rise1 = 0; seen1 = 1'b0; m1 = tx1[15];
    end
    always @(negedge sclk1) if (cs1 === 1'b0) begin
        idx1++;
        m1 = (idx1 < 16) ? tx1[15-idx1] : 1'b0;
    end
    always @(posedge sclk1) begin
        rise1++; mo1 = {mo1[14:0], mosi1};
        if (seen1) per1 = int'(($time - lt1) / 10);
        lt1 = $time; seen1 = 1'b1;
    end

    // D=2, NBYTES=2
    logic        ri2, ack2, busy2, cs2, sclk2, mosi2, m2, gon2;
    logic [31:0] addr2, dout2;
    logic [23:0] tx2;
    int          idx2, na2, gcnt2, gmin2;

    t07_spitft_rx #(.CLK_DIV(2), .NBYTES(2)) u2 (
        .clk(clk), .nrst(nrst), .ri(ri2), .address(addr2),
        .data_out(dout2), .ack(ack2), .busy(busy2),
        .chipSelect(cs2), .sclk(sclk2), .mosi(mosi2),
        .miso(m2 | (~nrst & rnd))
    );

    always @(negedge cs2) begin
        idx2 = 0; m2 = tx2[23];
    end
    always @(negedge sclk2) if (cs2 === 1'b0) begin
        idx2++;
        m2 = (idx2 < 24) ? tx2[23-idx2] : 1'b0;
    end
    always @(negedge clk) begin
        if (ack2 === 1'b1) begin
            na2++; gcnt2 = 1; gon2 = 1'b1;
        end else if (gon2) begin
            if (cs2) gcnt2++;
            else begin
                if (gcnt2 < gmin2) gmin2 = gcnt2;
                gon2 = 1'b0;
            end
        end
    end

    task automatic run4(input logic [31:0] a, input logic [39:0] t,
                        input int drop, output int lat);
        addr4 = a; tx4 = t; lat = -1;
        @(negedge clk); ri4 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 0) addr4 = ~a;
            if (c == drop) ri4 = 1'b0;
            if (ack4) begin lat = c; break; end
        end
        ri4 = 1'b0;
        if (lat < 0) check("ack4_timeout", 40'd0, 40'd1);
        else check("ack4_busy", 40'(busy4), 40'd1);
    endtask

    task automatic run1(input logic [31:0] a, input logic [15:0] t,
                        output int lat);
        addr1 = a; tx1 = t; lat = -1;
        @(negedge clk); ri1 = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            ri1 = 1'b0;
            if (c == 0) addr1 = ~a;
            if (ack1) begin lat = c; break; end
        end
        if (lat < 0) check("ack1_timeout", 40'd0, 40'd1);
    endtask

    task automatic run2(input logic [31:0] a, input logic [23:0] t,
                        output int lat);
        addr2 = a; tx2 = t; lat = -1;
        @(negedge clk); ri2 = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            ri2 = 1'b0;
            if (ack2) begin lat = c; break; end
        end
        if (lat < 0) check("ack2_timeout", 40'd0, 40'd1);
    endtask

    initial begin
        int lat;
        int acks;
        int base;
        nrst = 1'b0; rnd = 1'b0;
        ri4 = 0; ri1 = 0; ri2 = 0;
        addr4 = 0; addr1 = 0; addr2 = 0;
        tx4 = 0; tx1 = 0; tx2 = 0;
        mo4 = 0; mo1 = 0; m4 = 0; m1 = 0; m2 = 0;
        seen1 = 0; per1 = 0; lt1 = 0; gon2 = 0; gcnt2 = 0; gmin2 = 1000;
        idx4 = 0; idx1 = 0; idx2 = 0; rise4 = 0; rise1 = 0; csr4 = 0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ri4 = 1'($urandom); ri1 = 1'($urandom);
            ri2 = 1'($urandom); rnd = 1'($urandom);
        end
        check("rst_cs",   40'({cs4, cs2, cs1}), 40'b111);
        check("rst_sclk", 40'({sclk4, sclk2, sclk1}), 40'b000);
        check("rst_mosi", 40'({mosi4, mosi2, mosi1}), 40'b000);
        check("rst_ack",  40'({ack4, ack2, ack1}), 40'b000);
        check("rst_busy", 40'({busy4, busy2, busy1}), 40'b000);
        check("rst_dout", 40'(dout4 | dout2 | dout1), 40'd0);
        ri4 = 0; ri1 = 0; ri2 = 0; rnd = 0;
        @(negedge clk); nrst = 1'b1;
        repeat (2) @(negedge clk);
        na4 = 0; na2 = 0;

        run4(32'h0000_0040, {8'h00, 32'hDEAD_BEEF}, 0, lat);
        check("d4_lat",  40'(lat), 40'd328);
        check("d4_data", 40'(dout4), 40'hDEAD_BEEF);
        check("d4_cmd",  40'(mo4[39:32]), 40'h40);
        check("d4_mosi0", 40'(mo4[31:0]), 40'd0);
        check("d4_rises", 40'(rise4), 40'd40);
        check("d4_csrise", 40'(csr4), 40'd1);
        repeat (5) @(negedge clk);
        check("d4_acks", 40'(na4), 40'd1);
        check("d4_idle", 40'({busy4, cs4, sclk4}), 40'b010);

        run1(32'hFFFF_FFC0, {8'h00, 8'hA5}, lat);
        check("d1_lat",   40'(lat), 40'd34);
        check("d1_data",  40'(dout1), 40'h0000_00A5);
        check("d1_cmd",   40'(mo1[15:8]), 40'hC0);
        check("d1_rises", 40'(rise1), 40'd16);
        check("d1_period", 40'(per1), 40'd2);

        run2(32'h0000_0011, {8'h00, 16'hFFFF}, lat);
        check("d2_lat",   40'(lat), 40'd100);
        check("d2_ones",  40'(dout2), 40'h0000_FFFF);
        run2(32'h0000_0011, {8'hFF, 16'h0000}, lat);
        check("d2_zeros", 40'(dout2), 40'h0000_0000);

        repeat (3) @(negedge clk);
        na2 = 0; gmin2 = 1000; gon2 = 1'b0; acks = 0;
        addr2 = 32'h55; tx2 = {8'h00, 16'h1234};
        ri2 = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (ack2) acks++;
            if (acks == 3) break;
        end
        ri2 = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_acks", 40'(na2), 40'd3);
        check("hold_gap",  40'(gmin2 >= 2), 40'd1);
        check("hold_data", 40'(dout2), 40'h0000_1234);
        check("hold_stop", 40'({cs2, busy2}), 40'b10);

        base = na4;
        run4(32'h0000_0040, {8'h00, 32'h0BAD_F00D}, 10, lat);
        check("drop_lat",  40'(lat), 40'd328);
        check("drop_data", 40'(dout4), 40'h0BAD_F00D);
        repeat (20) @(negedge clk);
        check("drop_acks", 40'(na4 - base), 40'd1);
        check("drop_norestart", 40'({cs4, busy4}), 40'b10);

        base = na4;
        addr4 = 32'h40; tx4 = {8'h00, 32'h1234_5678};
        @(negedge clk); ri4 = 1'b1;
        acks = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            ri4 = 1'b0;
            if (rise4 == 20) begin acks = 1; break; end
        end
        check("abort_reach", 40'(acks), 40'd1);
        #2 nrst = 1'b0;
        #1;
        check("abort_cs",   40'(cs4), 40'd1);
        check("abort_sclk", 40'(sclk4), 40'd0);
        check("abort_busy", 40'(busy4), 40'd0);
        repeat (3) @(negedge clk);
        check("abort_noack", 40'(na4 - base), 40'd0);
        check("abort_dout",  40'(dout4), 40'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        run4(32'h0000_0040, {8'h00, 32'h1234_5678}, 0, lat);
        check("retry_lat",   40'(lat), 40'd328);
        check("retry_data",  40'(dout4), 40'h1234_5678);
        check("retry_rises", 40'(rise4), 40'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/t07_spitft_rx.md
Name: t07_spitft_rx

Overview:
- SPI read master for the RA8875 TFT controller. It is the read-back counterpart of the existing TFT write path.
- On a read request from the memory handler, it drives chip select low and shifts out an 8-bit command byte on MOSI.
- It then clocks in NBYTES bytes from MISO and returns them as a right-aligned 32-bit word with a one-cycle ack.
- SCLK is a divided, registered clock, never a gated system clock.

Parameters:
- CLK_DIV, default 4: system clocks per SCLK half-period. Legal range is 1 or more; 0 is illegal (elaboration error).
- NBYTES, default 4: data bytes read per transaction. Legal range is 1..4.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- ri  in  1  read request from memory handler (level).
- address  in  32  address[7:0] is the command byte sent; address[31:8] is ignored.
- data_out  out  32  assembled read data, right-aligned, upper bits zero.
- ack  out  1  one-cycle pulse; data_out is valid in that cycle.
- busy  out  1  high from transaction start until the ack cycle, inclusive.
- chipSelect  out  1  to RA8875, active low.
- sclk  out  1  to RA8875, idles low (SPI mode 0).
- mosi  out  1  to RA8875.
- miso  in  1  from RA8875.

Behaviour:
- Reset values: chipSelect=1, sclk=0, mosi=0, ack=0, busy=0, data_out=0; state=IDLE, all counters 0.
  - Reset is asynchronous. Asserting it mid-transaction aborts immediately, and chipSelect rises with no partial ack.
- Frame length: N = 8 + 8*NBYTES bits, MSB first. Let D = CLK_DIV.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - chipSelect=1, sclk=0, busy=0.
  - ri is sampled only here. On ri=1, latch address[7:0] into the command shift register and go to SETUP.
- SETUP (D cycles):
  - chipSelect=0, busy=1, sclk=0.
  - mosi = command bit 7 from the first SETUP cycle.
- SHIFT (2*N*D cycles):
  - A half-period counter counts 0..D-1; sclk toggles at terminal count.
  - Rising sclk transition: sample miso into the receive shift register (shift left). A bit counter increments.
  - Falling sclk transition: advance mosi to the next command bit. After the 8 command bits, mosi=0 for the rest of the frame.
  - The first 8 sampled bits (command phase) are discarded.
  - After the N-th falling edge, go to HOLD with sclk=0.
- HOLD (D cycles): chipSelect=0, sclk=0, then go to DONE.
- DONE (1 cycle):
  - chipSelect=1 and ack=1.
  - data_out is loaded in the same cycle with the last 8*NBYTES received bits, zero-extended; ack and new data_out appear together.
  - Go to IDLE.
- Latency: counting the first SETUP cycle as 0, ack is high in cycle (2N+2)*D.
  - Example: D=4, NBYTES=4 gives cycle 328.
- data_out holds its value until the next DONE. It is never cleared between transactions.
- ri changes during SETUP, SHIFT, HOLD or DONE are ignored; the transaction always completes.
  - If ri is still high in IDLE, a new transaction starts.
  - IDLE lasts at least 1 cycle, so chipSelect is high for at least 2 cycles (DONE + IDLE) between frames.
- address changes after latch have no effect on the frame in progress.
- sclk, chipSelect and mosi come directly from flops (glitch-free).
- Exactly N rising sclk edges occur per transaction.

Test Plan:
- Reset: hold nrst=0 with random ri/miso → chipSelect=1, sclk=0, mosi=0, ack=0, busy=0, data_out=0x00000000.
- D=4, NBYTES=4, address=0x00000040, slave model returns 0xDEADBEEF after the command byte → mosi shows 0x40 over the first 8 rising edges; 40 rising edges total; chipSelect low throughout; ack single pulse at cycle 328; data_out=0xDEADBEEF.
- D=1, NBYTES=1, address=0xFFFFFFC0, slave returns 0xA5 → command byte seen = 0xC0; data_out=0x000000A5; ack at cycle 34; sclk period = 2 clk.
- miso=1 during the command phase and 0 during data (D=2, NBYTES=2) → data_out=0x00000000. Repeat with the inverse pattern → data_out=0x0000FFFF.
- ri held high continuously for 3 transactions, and ri dropped at cycle 10 of a transaction →
  - each frame completes with exactly one ack;
  - chipSelect is high ≥2 cycles between frames;
  - a dropped-ri frame still completes with no restart.
- nrst pulsed low during SHIFT (bit 20) → chipSelect=1 and sclk=0 immediately, no ack. The next request yields a full, correct 0x12345678 read.
